riscv_pc_ctrl: RTL

//  Fetch sequencer that drives the PC register's nextpc/stallpc inputs.

---
 rtl/riscv_pc_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/riscv_pc_ctrl.sv
// Fetch sequencer feeding the PC register: boot delay, redirect arbitration
// (trap > xret > branch > sequential), pending redirect across imem stalls.
// Optional WFI state enabled by defining RISCV_PC_CTRL_WFI_EN.
module riscv_pc_ctrl #(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned BOOT_CYCLES  = 1
) (
  input  logic        i_riscv_pcctrl_clk,
  input  logic        i_riscv_pcctrl_rst_n,
  input  logic [63:0] i_riscv_pcctrl_pc,
  input  logic        i_riscv_pcctrl_cinstr,
  input  logic        i_riscv_pcctrl_imem_ready,
  input  logic        i_riscv_pcctrl_hazard_stall,
  input  logic        i_riscv_pcctrl_trap_valid,
  input  logic [63:0] i_riscv_pcctrl_trap_vec,
  input  logic        i_riscv_pcctrl_xret_valid,
  input  logic [63:0] i_riscv_pcctrl_xret_pc,
  input  logic        i_riscv_pcctrl_br_valid,
  input  logic [63:0] i_riscv_pcctrl_br_target,
  output logic [63:0] o_riscv_pcctrl_nextpc,
  output logic        o_riscv_pcctrl_stallpc,
  output logic        o_riscv_pcctrl_flush,
  output logic        o_riscv_pcctrl_fetch_req,
  output logic [1:0]  o_riscv_pcctrl_state
`ifdef RISCV_PC_CTRL_WFI_EN
  ,
  input  logic        i_riscv_pcctrl_wfi,
  input  logic        i_riscv_pcctrl_irq_pending
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_WFI  = 2'b11
  } state_e;

  localparam logic [63:0] ALIGN_MASK = ~64'd1;
  localparam logic [7:0]  BOOT_INIT  = 8'(BOOT_CYCLES);

  state_e      state, state_nxt;
  logic [7:0]  boot_cnt;
  logic [63:0] pending, pending_nxt;
  logic [63:0] nextpc_raw;
  logic [63:0] pc_seq;
  logic [63:0] redir_target;
  logic [63:0] trap_target;
  logic        redir;
  logic        boot_last;

  assign redir       = i_riscv_pcctrl_trap_valid | i_riscv_pcctrl_xret_valid |
                       i_riscv_pcctrl_br_valid;
  assign trap_target = i_riscv_pcctrl_trap_vec & ALIGN_MASK;
  assign redir_target = (i_riscv_pcctrl_trap_valid ? i_riscv_pcctrl_trap_vec :
                         i_riscv_pcctrl_xret_valid ? i_riscv_pcctrl_xret_pc :
                                                     i_riscv_pcctrl_br_target) & ALIGN_MASK;
  assign pc_seq      = i_riscv_pcctrl_pc + (i_riscv_pcctrl_cinstr ? 64'd2 : 64'd4);
  // Treat a zero count as final too, so BOOT can never stall forever.
  assign boot_last   = (boot_cnt <= 8'd1);

  always_ff @(posedge i_riscv_pcctrl_clk) begin
    if (!i_riscv_pcctrl_rst_n) begin
      state    <= ST_BOOT;
      boot_cnt <= BOOT_INIT;
      pending  <= '0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      boot_cnt <= (state == ST_BOOT) ? boot_cnt - 8'd1 : BOOT_INIT;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    nextpc_raw  = i_riscv_pcctrl_pc;
    o_riscv_pcctrl_stallpc   = 1'b1;
    o_riscv_pcctrl_flush     = 1'b0;
    o_riscv_pcctrl_fetch_req = 1'b0;
    case (state)
      ST_BOOT: begin
        nextpc_raw           = RESET_VECTOR;
        o_riscv_pcctrl_flush = 1'b1;
        if (boot_last) begin
          o_riscv_pcctrl_stallpc = 1'b0;
          state_nxt              = ST_RUN;
        end
      end
      ST_RUN: begin
        o_riscv_pcctrl_fetch_req = 1'b1;
        if (redir) begin
          // A redirect overrides any hazard stall; it only waits on imem.
          nextpc_raw             = redir_target;
          o_riscv_pcctrl_flush   = 1'b1;
          o_riscv_pcctrl_stallpc = !i_riscv_pcctrl_imem_ready;
          if (!i_riscv_pcctrl_imem_ready) begin
            pending_nxt = redir_target;
            state_nxt   = ST_HOLD;
          end
        end else begin
          nextpc_raw             = pc_seq;
          o_riscv_pcctrl_stallpc = !i_riscv_pcctrl_imem_ready |
                                   i_riscv_pcctrl_hazard_stall;
`ifdef RISCV_PC_CTRL_WFI_EN
          if (i_riscv_pcctrl_wfi) state_nxt = ST_WFI;
`endif
        end
      end
      ST_HOLD: begin
        o_riscv_pcctrl_flush   = 1'b1;
        o_riscv_pcctrl_stallpc = !i_riscv_pcctrl_imem_ready;
        if (i_riscv_pcctrl_trap_valid) begin
          nextpc_raw  = trap_target;
          pending_nxt = trap_target;
        end else begin
          nextpc_raw  = pending;
        end
        if (i_riscv_pcctrl_imem_ready) state_nxt = ST_RUN;
      end
      ST_WFI: begin
`ifdef RISCV_PC_CTRL_WFI_EN
        if (i_riscv_pcctrl_trap_valid) begin
          nextpc_raw             = trap_target;
          o_riscv_pcctrl_flush   = 1'b1;
          o_riscv_pcctrl_stallpc = !i_riscv_pcctrl_imem_ready;
          if (i_riscv_pcctrl_imem_ready) begin
            state_nxt = ST_RUN;
          end else begin
            pending_nxt = trap_target;
            state_nxt   = ST_HOLD;
          end
        end else if (i_riscv_pcctrl_irq_pending) begin
          state_nxt = ST_RUN;
        end
`else
        state_nxt = ST_BOOT;
`endif
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign o_riscv_pcctrl_nextpc = nextpc_raw & ALIGN_MASK;
  assign o_riscv_pcctrl_state  = state;

endmodule
